// File: rtl/core_ex_mdu_seq_if.sv
// Handshake bundle between the EX stage and the M-extension sequencer.
//   master (EX side): drives op, operands, op_wait_handle, out_ack, flush
//   slave  (MDU side): drives op_ready, out, busy
interface core_ex_mdu_seq_if #(parameter int WIDTH = 32);
  logic [2:0]       op;
  logic             op_wait_handle;
  logic             op_ready;
  logic             out_ack;
  logic             flush;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output op, op_wait_handle, out_ack, flush, in1, in2,
    input  op_ready, out, busy
  );

  modport slave (
    input  op, op_wait_handle, out_ack, flush, in1, in2,
    output op_ready, out, busy
  );
endinterface

// File: rtl/core_ex_mdu_seq.sv
// RV32M multiply/divide sequencer for the EX stage.
// Iterative shift-add multiply / restoring divide, one bit per cycle,
// WIDTH iterations. Divide-by-zero and signed overflow finish in one cycle.
// Ports:
//   clk   - core clock, rising edge
//   rest  - asynchronous active-low reset
//   mdu   - slave side of core_ex_mdu_seq_if (op/in1/in2/op_wait_handle/
//           out_ack/flush in; op_ready/out/busy out)
module core_ex_mdu_seq #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rest,
  core_ex_mdu_seq_if.slave mdu
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;     // negate product / quotient
  logic               rneg_q, rneg_d;   // negate remainder (dividend sign)
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;   // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] prod_q, prod_d;   // product; low half is dividend/quotient when dividing
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   out_q, out_d;

  // ---- operand decode at accept ----
  logic             s1, s2, is_div, ovf;
  logic [WIDTH-1:0] mag1, mag2;

  always_comb begin
    s1     = mdu.in1[WIDTH-1] & (mdu.op inside {3'd1, 3'd2, 3'd4, 3'd6});
    s2     = mdu.in2[WIDTH-1] & (mdu.op inside {3'd1, 3'd4, 3'd6});
    mag1   = s1 ? (~mdu.in1 + 1'b1) : mdu.in1;
    mag2   = s2 ? (~mdu.in2 + 1'b1) : mdu.in2;
    is_div = mdu.op[2];
    // DIV/REM only: most negative / -1
    ovf    = is_div & ~mdu.op[0] & (mdu.in1 == MIN_NEG) & (mdu.in2 == '1);
  end

  // ---- one iteration step and final result selection ----
  logic [WIDTH:0]     mul_add, shl, diff;
  logic [2*WIDTH-1:0] mul_nx, prod_fin;
  logic               qbit;
  logic [WIDTH-1:0]   rem_nx, quo_nx, quo_fin, rem_fin, res_fin;

  always_comb begin
    // multiply: add multiplicand into the high half when the LSB is set, shift right
    mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, dvsr_q} : '0);
    mul_nx   = {mul_add, prod_q[WIDTH-1:1]};
    // divide: bring in next dividend bit, keep subtraction if it does not borrow
    shl      = {rem_q, prod_q[WIDTH-1]};
    diff     = shl - {1'b0, dvsr_q};
    qbit     = ~diff[WIDTH];
    rem_nx   = qbit ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    quo_nx   = {prod_q[WIDTH-2:0], qbit};
    prod_fin = neg_q  ? (~mul_nx + 1'b1) : mul_nx;
    quo_fin  = neg_q  ? (~quo_nx + 1'b1) : quo_nx;
    rem_fin  = rneg_q ? (~rem_nx + 1'b1) : rem_nx;
    if (!op_q[2])     res_fin = (op_q[1:0] == 2'd0) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
    else if (op_q[1]) res_fin = rem_fin;
    else              res_fin = quo_fin;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dvsr_d  = dvsr_q;
    prod_d  = prod_q;
    rem_d   = rem_q;
    out_d   = out_q;
    if (mdu.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (mdu.op_wait_handle) begin
          op_d   = mdu.op;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          dvsr_d = is_div ? mag2 : mag1;
          prod_d = {{WIDTH{1'b0}}, is_div ? mag1 : mag2};
          rem_d  = '0;
          cnt_d  = '0;
          if (is_div && (mdu.in2 == '0)) begin
            out_d   = mdu.op[1] ? mdu.in1 : '1;
            state_d = S_DONE;
          end else if (ovf) begin
            out_d   = mdu.op[1] ? '0 : MIN_NEG;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
        S_BUSY: begin
          if (op_q[2]) begin
            prod_d = {prod_q[2*WIDTH-1:WIDTH], quo_nx};
            rem_d  = rem_nx;
          end else begin
            prod_d = mul_nx;
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) begin
            out_d   = res_fin;
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
        S_DONE: if (mdu.out_ack) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dvsr_q  <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dvsr_q  <= dvsr_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      out_q   <= out_d;
    end
  end

  assign mdu.op_ready = (state_q == S_DONE);
  assign mdu.busy     = (state_q == S_BUSY);
  assign mdu.out      = out_q;
endmodule

// File: tb/tb_core_ex_mdu_seq.sv
module tb_core_ex_mdu_seq;
  logic clk  = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  core_ex_mdu_seq_if bus();
  core_ex_mdu_seq dut (.clk(clk), .rest(rest), .mdu(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- reference arithmetic straight from the RV32M rules ----
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sb, r;
    sa = a; sb = b;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        r = sa / sb; return r;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        r = sa % sb; return r;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // ---- transaction-level model: result after 1 or 33 edges, held until ack ----
  bit          m_busy = 0, m_ready = 0;
  int          m_left = 0;
  logic [31:0] m_out = 0, m_res = 0;

  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      m_busy <= 0; m_ready <= 0; m_left <= 0; m_out <= 0;
    end else if (bus.flush) begin
      m_busy <= 0; m_ready <= 0; m_left <= 0;
    end else if (m_ready) begin
      if (bus.out_ack) m_ready <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin m_busy <= 0; m_ready <= 1; m_out <= m_res; end
      m_left <= m_left - 1;
    end else if (bus.op_wait_handle) begin
      if (is_fast(bus.op, bus.in1, bus.in2)) begin
        m_ready <= 1; m_out <= ref_res(bus.op, bus.in1, bus.in2);
      end else begin
        m_busy <= 1; m_left <= 32; m_res <= ref_res(bus.op, bus.in1, bus.in2);
      end
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    check("cyc op_ready", {31'b0, bus.op_ready}, {31'b0, m_ready});
    check("cyc busy", {31'b0, bus.busy}, {31'b0, m_busy});
    check("cyc out", bus.out, m_out);
  end

  // issue, wait for result with bounded latency, hold ack off ackw cycles, ack
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int ackw, input string nm);
    int lat, want;
    bus.op = o; bus.in1 = a; bus.in2 = b; bus.op_wait_handle = 1;
    want = is_fast(o, a, b) ? 1 : 33;
    lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!bus.op_ready && lat < 100);
    check({nm, " latency"}, lat, want);
    check(nm, bus.out, exp);
    for (int i = 0; i < ackw; i++) begin
      @(negedge clk);
      check({nm, " hold ready"}, {31'b0, bus.op_ready}, 32'd1);
      check({nm, " hold out"}, bus.out, exp);
    end
    bus.out_ack = 1;
    @(negedge clk);
    check({nm, " ready after ack"}, {31'b0, bus.op_ready}, 32'd0);
    bus.out_ack = 0; bus.op_wait_handle = 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] prev, a, b;
    logic [2:0]  o;
    int k;
    bus.op = 0; bus.in1 = 0; bus.in2 = 0;
    bus.op_wait_handle = 0; bus.out_ack = 0; bus.flush = 0;

    // model pins
    check("pin mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("pin mulh", ref_res(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("pin mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'd2), 32'hFFFF_FFFF);
    check("pin div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    check("pin rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    #2 rest = 0;
    #1;
    check("reset ready", {31'b0, bus.op_ready}, 32'd0);
    check("reset out", bus.out, 32'd0);
    repeat (2) @(negedge clk);
    #2 rest = 1;
    @(negedge clk);

    // reset mid-BUSY at counter 15
    bus.op = 3'd0; bus.in1 = 32'd11; bus.in2 = 32'd13; bus.op_wait_handle = 1;
    repeat (16) @(negedge clk);
    check("pre-reset busy", {31'b0, bus.busy}, 32'd1);
    #2 rest = 0;
    #1;
    check("midrst busy", {31'b0, bus.busy}, 32'd0);
    check("midrst ready", {31'b0, bus.op_ready}, 32'd0);
    check("midrst out", bus.out, 32'd0);
    bus.op_wait_handle = 0;
    @(negedge clk);
    #2 rest = 1;
    @(negedge clk);
    run_op(3'd0, 32'd5, 32'd6, 32'h1E, 0, "MUL 5*6");

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, "MUL neg");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, "MULH");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, "MULHU");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 0, "MULHSU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, "DIV");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, "REM");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 0, "DIVU");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 0, "REMU");
    run_op(3'd4, 32'd55, 32'd0, 32'hFFFF_FFFF, 0, "DIV by 0");
    run_op(3'd6, 32'h1234, 32'd0, 32'h1234, 0, "REM by 0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "DIV ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "REM ovf");
    // backpressure, then the very next op must take a full 33 edges
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 5, "DIVU bp");
    run_op(3'd0, 32'd9, 32'd9, 32'd81, 0, "MUL after bp");

    // flush at counter 10
    prev = bus.out;
    bus.op = 3'd4; bus.in1 = 32'd1000; bus.in2 = 32'd7; bus.op_wait_handle = 1;
    repeat (11) @(negedge clk);
    bus.flush = 1; bus.op_wait_handle = 0;
    @(negedge clk);
    bus.flush = 0;
    check("flush busy", {31'b0, bus.busy}, 32'd0);
    check("flush ready", {31'b0, bus.op_ready}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush out kept", bus.out, prev);

    // flush together with a request in IDLE
    bus.op = 3'd0; bus.in1 = 32'd9; bus.in2 = 32'd9; bus.op_wait_handle = 1; bus.flush = 1;
    @(negedge clk);
    check("flush+req busy", {31'b0, bus.busy}, 32'd0);
    check("flush+req ready", {31'b0, bus.op_ready}, 32'd0);
    bus.flush = 0; bus.op_wait_handle = 0;
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 0, "MUL 3*4");

    // randomized traffic, occasionally flushed (sometimes in DONE)
    for (int i = 0; i < 150; i++) begin
      o = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(1, 40);
        bus.op = o; bus.in1 = a; bus.in2 = b; bus.op_wait_handle = 1;
        repeat (k) @(negedge clk);
        bus.flush = 1; bus.op_wait_handle = 0;
        @(negedge clk);
        bus.flush = 0;
      end else begin
        run_op(o, a, b, ref_res(o, a, b), $urandom_range(0, 3), "rand");
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
